// File: rtl/waveform_analyzer_pkg.sv
// rtl/waveform_analyzer_pkg.sv - shared FSM encoding and default thresholds for the waveform analyzer
package waveform_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOW  = 2'd1,
        ST_WAIT_EDGE = 2'd2,
        ST_MEASURE   = 2'd3
    } state_t;

    localparam logic [7:0] DEF_HI_TH = 8'd136;
    localparam logic [7:0] DEF_LO_TH = 8'd120;
    localparam int         DEF_CNT_W = 16;

endpackage

// File: rtl/waveform_analyzer_crossing.sv
// rtl/waveform_analyzer_crossing.sv - hysteresis comparator: arms below LO_TH, pulses rise at HI_TH while armed
module crossing_detector
    import waveform_analyzer_pkg::*;
#(
    parameter logic [7:0] HI_TH = DEF_HI_TH,
    parameter logic [7:0] LO_TH = DEF_LO_TH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       in_valid,
    input  logic       enable,
    input  logic       clear,
    output logic       low,
    output logic       rise
);

    logic armed;

    assign low  = enable && in_valid && (in <= LO_TH);
    assign rise = enable && in_valid && armed && (in >= HI_TH);

    // A rise consumes the arm; only a later low sample can re-arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (clear || rise) begin
            armed <= 1'b0;
        end else if (low) begin
            armed <= 1'b1;
        end
    end

endmodule

// File: rtl/waveform_analyzer.sv
// rtl/waveform_analyzer.sv - measures period and min/max/peak-to-peak of one waveform cycle on request
module waveform_analyzer
    import waveform_analyzer_pkg::*;
#(
    parameter logic [7:0] HI_TH = DEF_HI_TH,
    parameter logic [7:0] LO_TH = DEF_LO_TH,
    parameter int         CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       vmin,
    output logic [7:0]       vmax,
    output logic [7:0]       vpp
);

    // One below all-ones: the sample arriving at this count is the timeout sample.
    localparam logic [CNT_W-1:0] CNT_LAST = ~CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       trk_min;
    logic [7:0]       trk_max;
    logic             low;
    logic             rise;
    logic             expired;

    crossing_detector #(
        .HI_TH(HI_TH),
        .LO_TH(LO_TH)
    ) u_cross (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .in_valid(in_valid),
        .enable  (state != ST_IDLE),
        .clear   (state == ST_IDLE),
        .low     (low),
        .rise    (rise)
    );

    assign busy    = (state != ST_IDLE);
    assign expired = busy && in_valid && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            trk_min <= '0;
            trk_max <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            period  <= '0;
            vmin    <= '0;
            vmax    <= '0;
            vpp     <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    state   <= ST_WAIT_LOW;
                    cnt     <= '0;
                    timeout <= 1'b0;
                end
            end else if (expired) begin
                // Timeout wins over a simultaneous closing crossing; levels keep old values.
                state   <= ST_IDLE;
                period  <= '1;
                timeout <= 1'b1;
                done    <= 1'b1;
            end else if (in_valid) begin
                case (state)
                    ST_WAIT_LOW: begin
                        cnt <= cnt + CNT_W'(1);
                        if (low) state <= ST_WAIT_EDGE;
                    end
                    ST_WAIT_EDGE: begin
                        if (rise) begin
                            state   <= ST_MEASURE;
                            cnt     <= '0;
                            trk_min <= in;
                            trk_max <= in;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        if (rise) begin
                            state  <= ST_IDLE;
                            period <= cnt + CNT_W'(1);
                            vmin   <= trk_min;
                            vmax   <= trk_max;
                            vpp    <= trk_max - trk_min;
                            done   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (in < trk_min) trk_min <= in;
                            if (in > trk_max) trk_max <= in;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_waveform_analyzer.sv
// tb/tb_waveform_analyzer.sv - directed table-driven bench for waveform_analyzer
module tb_waveform_analyzer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in;

    logic        busy16, done16, to16;
    logic [15:0] per16;
    logic [7:0]  min16, max16, pp16;
    logic        busy8, done8, to8;
    logic [7:0]  per8;
    logic [7:0]  min8, max8, pp8;

    int errors = 0;
    int checks = 0;

    waveform_analyzer dut16 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in(in),
        .busy(busy16), .done(done16), .timeout(to16), .period(per16),
        .vmin(min16), .vmax(max16), .vpp(pp16)
    );

    waveform_analyzer #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in(in),
        .busy(busy8), .done(done8), .timeout(to8), .period(per8),
        .vmin(min8), .vmax(max8), .vpp(pp8)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        bit          sparse;
        bit          use8;
        int          n;
        logic [15:0] per;
        logic [7:0]  vmin;
        logic [7:0]  vmax;
        logic [7:0]  vpp;
        logic        to;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] wave(input int kind, input int k);
        case (kind)
            0:       return ((k % 20) < 10) ? 8'd255 : 8'd0;
            1:       return ((k % 20) < 10) ? 8'd200 : 8'd50;
            2:       return 8'(100 + (k % 101));
            default: return 8'd128;
        endcase
    endfunction

    // Start with a qualified junk sample in the start cycle, then stream samples until done or max_samp.
    task automatic run(input int kind, input bit sparse, input bit use8, input int restart_at,
                       input int max_samp, output int nsamp, output bit got_done);
        start = 1'b1; in_valid = 1'b1; in = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        nsamp = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 3000 && nsamp < max_samp; cyc++) begin
            in_valid = !sparse || (cyc % 4 == 0);
            in = in_valid ? wave(kind, nsamp) : 8'd0;
            start = (cyc == restart_at);
            @(posedge clk);
            if (in_valid) nsamp++;
            #1;
            if (use8 ? done8 : done16) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0; in_valid = 1'b0; in = 8'd0;
    endtask

    initial begin
        int  nsamp;
        bit  got;
        int  extra_done;

        vecs[0] = '{"square_dense",  0, 1'b0, 1'b0,  41, 16'd20,   8'd0,   8'd255, 8'd255, 1'b0};
        vecs[1] = '{"square_sparse", 0, 1'b1, 1'b0,  41, 16'd20,   8'd0,   8'd255, 8'd255, 1'b0};
        vecs[2] = '{"sawtooth",      2, 1'b0, 1'b0, 138, 16'd101,  8'd100, 8'd200, 8'd100, 1'b0};
        vecs[3] = '{"square_50_200", 1, 1'b0, 1'b0,  41, 16'd20,   8'd50,  8'd200, 8'd150, 1'b0};
        vecs[4] = '{"const_timeout", 3, 1'b0, 1'b1, 255, 16'h00FF, 8'd50,  8'd200, 8'd150, 1'b1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy16, 0);
        check("rst_done", done16, 0);
        check("rst_timeout", to16, 0);
        check("rst_period", per16, 0);
        check("rst_vmin", min16, 0);
        check("rst_vmax", max16, 0);
        check("rst_vpp", pp16, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run(vecs[i].kind, vecs[i].sparse, vecs[i].use8, -1, 100000, nsamp, got);
            check({vecs[i].name, "_done"}, got, 1);
            check({vecs[i].name, "_samples"}, nsamp, vecs[i].n);
            if (vecs[i].use8) begin
                check({vecs[i].name, "_period"}, {8'h0, per8}, vecs[i].per);
                check({vecs[i].name, "_vmin"}, min8, vecs[i].vmin);
                check({vecs[i].name, "_vmax"}, max8, vecs[i].vmax);
                check({vecs[i].name, "_vpp"}, pp8, vecs[i].vpp);
                check({vecs[i].name, "_timeout"}, to8, vecs[i].to);
                check({vecs[i].name, "_busy"}, busy8, 0);
            end else begin
                check({vecs[i].name, "_period"}, per16, vecs[i].per);
                check({vecs[i].name, "_vmin"}, min16, vecs[i].vmin);
                check({vecs[i].name, "_vmax"}, max16, vecs[i].vmax);
                check({vecs[i].name, "_vpp"}, pp16, vecs[i].vpp);
                check({vecs[i].name, "_timeout"}, to16, vecs[i].to);
                check({vecs[i].name, "_busy"}, busy16, 0);
            end
            @(posedge clk); #1;
            check({vecs[i].name, "_done_pulse"}, vecs[i].use8 ? done8 : done16, 0);
        end

        // A fresh start clears the timeout flag of the 8-bit instance.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("timeout_cleared", to8, 0);
        check("restart_busy", busy8, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        run(0, 1'b0, 1'b0, -1, 100000, nsamp, got);
        check("pre_reset_period", per16, 20);

        // Reset in the middle of MEASURE, colliding with start and a qualified sample.
        run(0, 1'b0, 1'b0, -1, 25, nsamp, got);
        check("mid_measure_busy", busy16, 1);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in = 8'd255;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in = 8'd0;
        check("mid_rst_busy", busy16, 0);
        check("mid_rst_done", done16, 0);
        check("mid_rst_period", per16, 0);
        check("mid_rst_vmin", min16, 0);
        check("mid_rst_vmax", max16, 0);
        check("mid_rst_vpp", pp16, 0);
        repeat (2) @(posedge clk);
        #1;
        run(0, 1'b0, 1'b0, -1, 100000, nsamp, got);
        check("post_rst_done", got, 1);
        check("post_rst_period", per16, 20);
        check("post_rst_vmax", max16, 255);

        // Second start inside MEASURE must be ignored.
        run(0, 1'b0, 1'b0, 25, 100000, nsamp, got);
        check("restart_done", got, 1);
        check("restart_samples", nsamp, 41);
        check("restart_period", per16, 20);
        extra_done = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in = wave(0, c);
            @(posedge clk); #1;
            if (done16) extra_done++;
        end
        in_valid = 1'b0;
        check("restart_single_done", extra_done, 0);
        check("restart_idle", busy16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
